if_fetch_ctrl: RTL and testbench
================================

# if_fetch_ctrl

Instruction-fetch sequencer for the MIPS32 pipelined core. It owns the program counter and drives the instruction-memory read handshake. It presents fetched instructions, PC, PC+4 and delay-slot status to the IF/ID pipeline register, along with the `IF_Stall` and `IF_Flush` controls that register consumes. It absorbs variable memory latency, branch redirects, branch-likely cancellation and exception redirects, including redirects that arrive while a read is still outstanding.

## Interface
- `RESET_VECTOR`, default `32'hBFC0_0000`: PC loaded on reset.
- `clock` in 1: single core clock.
- `reset` in 1: synchronous, active-high.
- `ID_Stall` in 1: ID stage holding; the IF/ID register does not capture.
- `ID_PCSrc` in 1: taken branch/jump resolved in ID.
- `ID_TargetPC` in 32: redirect target when `ID_PCSrc`.
- `ID_IsBranch` in 1: ID holds a branch/jump, so the IF slot is its delay slot.
- `ID_CancelBDS` in 1: branch-likely not taken; squash the IF slot.
- `Exc_Redirect` in 1: exception/ERET redirect, highest priority.
- `Exc_Vector` in 32: target for `Exc_Redirect`.
- `InstMem_Ready` in 1: read data valid this cycle; completes the request.
- `InstMem_Data` in 32: read data.
- `InstMem_Read` out 1: read request.
- `InstMem_Address` out 30: word address, equal to `PC[31:2]`.
- `IF_Instruction` out 32: instruction to IF/ID.
- `IF_PC` out 32: PC of `IF_Instruction`.
- `IF_PCAdd4` out 32: `IF_PC + 4`, mod 2^32.
- `IF_IsBDS` out 1: instruction is a branch delay slot.
- `IF_Stall` out 1: no valid instruction this cycle.
- `IF_Flush` out 1: squash the IF slot.
- `IF_EXC_AdIF` out 1: fetch address error.

## Operation
- **Registers:** `PC`, `state`, `hold_instr`.
- **States:**
  - FETCH: request outstanding.
  - HOLD: data captured, waiting for ID to un-stall.
  - DISCARD: redirect arrived during an outstanding read; drop its data.
- **Memory protocol:**
  - `InstMem_Read` is 1 in FETCH and DISCARD.
  - Address is held stable until `InstMem_Ready` is sampled high.
  - Zero-wait memory (Ready in the same cycle as Read) is legal.
- **Valid instruction:** `valid = (FETCH & InstMem_Ready) | HOLD`.
  - `IF_Instruction = HOLD ? hold_instr : InstMem_Data`.
  - `IF_Stall = ~valid`.
- **Consume:** `valid & ~ID_Stall`.
  - Next PC is `ID_PCSrc ? ID_TargetPC : PC+4`.
  - Next state is FETCH.
- **Stall with data:** FETCH & Ready & `ID_Stall` → HOLD; `hold_instr <= InstMem_Data`.
- **Delay slot and flush:**
  - `IF_IsBDS = ID_IsBranch`, combinational.
  - `IF_Flush = Exc_Redirect | ID_CancelBDS`.
  - A flush does not block consume; the IF/ID register zeroes the instruction.
- **Exception redirect:** `Exc_Redirect` overrides every other event, independent of `ID_Stall`.
  - `PC <= Exc_Vector`.
  - If in FETCH without Ready, or already in DISCARD: next state DISCARD.
  - Otherwise: next state FETCH.
- **DISCARD:** on Ready, go to FETCH at the current `PC`; the data is ignored.
- **PC arithmetic:** wraps mod 2^32.

## Timing
- **Reset values:** `PC=RESET_VECTOR`, `state=FETCH`, `hold_instr=0`.
  - While `reset` is high: `InstMem_Read=0`, `IF_Stall=1`, `IF_Flush=0`, `IF_EXC_AdIF=0`, `IF_Instruction=0`.
  - `IF_PC=RESET_VECTOR` and `IF_PCAdd4=RESET_VECTOR+4`.
- **First request:** issued in the first cycle after reset deasserts.
- **Mid-operation reset:** an outstanding request is abandoned; memory shares the same reset.
- **Throughput:** with zero-wait memory and no stalls, one instruction per cycle.
- **Redirect latency:** a redirect target is fetched in the cycle after the redirect edge, or after the drain in DISCARD.
- **Simultaneous `ID_PCSrc` and `Exc_Redirect`:** the exception wins.
- **Simultaneous `ID_CancelBDS` and `ID_Stall`:** `IF_Flush` is still asserted; the IF/ID register holds.

## Configuration
- **`IF_ADDR_ERR_EN` defined:**
  - If `PC[1:0]!=0`, then `InstMem_Read=0`, `IF_EXC_AdIF=1`, `IF_Stall=0`, `IF_Instruction=0`.
  - The slot is consumed normally; PC advances only via redirect.
- **`IF_ADDR_ERR_EN` undefined:**
  - `PC[1:0]` is ignored.
  - `IF_EXC_AdIF` is tied to 0.

## Test plan
- **Reset and sequential fetch:** release reset with zero-wait memory → `InstMem_Address` = `0x2FF00000`, `0x2FF00001`, … on consecutive cycles; `IF_Stall=0` throughout.
- **Wait states:** memory with 3 wait states → `IF_Stall=1` for 3 cycles, then the instruction appears with `IF_PC=0xBFC00000`.
- **Branch:** `ID_IsBranch=1`, `ID_PCSrc=1`, target `0x80000100` while the BDS at `0xBFC00008` is consumed → `IF_IsBDS=1`; next `IF_PC=0x80000100`.
- **Exception during outstanding read:** `Exc_Redirect` to `0x80000180` while FETCH waits → DISCARD; old data dropped; next request address `0x20000060`.
- **Stall then release:** `ID_Stall` high as Ready arrives with `0x24020005` → HOLD; `IF_Instruction=0x24020005` is held; `ID_Stall` low → consume; PC+4 is fetched.
- **Misaligned target (`IF_ADDR_ERR_EN` defined):** redirect to `0x80000102` → `IF_EXC_AdIF=1`, `InstMem_Read=0`.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the instruction-memory read handshake and feeds IF/ID.
// Optional fetch address-error detection is enabled by defining IF_ADDR_ERR_EN.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ID_Stall,
  input  logic        ID_PCSrc,
  input  logic [31:0] ID_TargetPC,
  input  logic        ID_IsBranch,
  input  logic        ID_CancelBDS,
  input  logic        Exc_Redirect,
  input  logic [31:0] Exc_Vector,
  input  logic        InstMem_Ready,
  input  logic [31:0] InstMem_Data,
  output logic        InstMem_Read,
  output logic [29:0] InstMem_Address,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PCAdd4,
  output logic        IF_IsBDS,
  output logic        IF_Stall,
  output logic        IF_Flush,
  output logic        IF_EXC_AdIF,
  output logic [1:0]  dbg_state
);

  // Memory handshake: InstMem_Read high means a read is outstanding at InstMem_Address;
  // the read completes in the cycle InstMem_Ready is sampled high (same cycle is legal).
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] hold_instr;
  logic        hold_load;
  logic        mis;
  logic        valid;
  logic        consume;
  logic        pending;

`ifdef IF_ADDR_ERR_EN
  // A misaligned PC never issues a read; the slot carries the address error instead.
  assign mis = ~reset & (state == FETCH) & (pc[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign valid   = ~reset & (((state == FETCH) & (InstMem_Ready | mis)) | (state == HOLD));
  assign consume = valid & ~ID_Stall;
  // A read is still in flight after this edge unless Ready completes it now.
  assign pending = ((state == FETCH) & ~mis & ~InstMem_Ready) |
                   ((state == DISCARD) & ~InstMem_Ready);

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    hold_load = 1'b0;
    if (Exc_Redirect) begin
      pc_n    = Exc_Vector;
      state_n = pending ? DISCARD : FETCH;
    end else if (consume) begin
      state_n = FETCH;
      if (ID_PCSrc)
        pc_n = ID_TargetPC;
      else if (!mis)
        pc_n = pc + 32'd4;
    end else if ((state == FETCH) && InstMem_Ready && !mis) begin
      state_n   = HOLD;
      hold_load = 1'b1;
    end else if ((state == DISCARD) && InstMem_Ready) begin
      state_n = FETCH;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_VECTOR;
      hold_instr <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (hold_load)
        hold_instr <= InstMem_Data;
    end
  end

  assign IF_PC           = reset ? RESET_VECTOR : pc;
  assign IF_PCAdd4       = IF_PC + 32'd4;
  assign InstMem_Address = IF_PC[31:2];
  assign InstMem_Read    = ~reset & (((state == FETCH) & ~mis) | (state == DISCARD));
  assign IF_Instruction  = (reset | mis) ? 32'd0 :
                           ((state == HOLD) ? hold_instr : InstMem_Data);
  assign IF_Stall        = ~valid;
  assign IF_Flush        = ~reset & (Exc_Redirect | ID_CancelBDS);
  assign IF_IsBDS        = ID_IsBranch;
  assign IF_EXC_AdIF     = mis;
  assign dbg_state       = state;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios with a wait-state memory model and an expected-queue scoreboard.
module tb_if_fetch_ctrl;

  localparam int W = 65;  // {is_bds, pc, instruction}

  logic        clock;
  logic        reset;
  logic        ID_Stall, ID_PCSrc, ID_IsBranch, ID_CancelBDS, Exc_Redirect;
  logic [31:0] ID_TargetPC, Exc_Vector;
  logic        InstMem_Ready;
  logic [31:0] InstMem_Data;
  logic        InstMem_Read;
  logic [29:0] InstMem_Address;
  logic [31:0] IF_Instruction, IF_PC, IF_PCAdd4;
  logic        IF_IsBDS, IF_Stall, IF_Flush, IF_EXC_AdIF;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  int          wait_states = 0;
  int          mem_cnt = 0;
  logic        data_override_en = 1'b0;
  logic [31:0] data_override = 32'd0;

  if_fetch_ctrl dut (
    .clock(clock), .reset(reset),
    .ID_Stall(ID_Stall), .ID_PCSrc(ID_PCSrc), .ID_TargetPC(ID_TargetPC),
    .ID_IsBranch(ID_IsBranch), .ID_CancelBDS(ID_CancelBDS),
    .Exc_Redirect(Exc_Redirect), .Exc_Vector(Exc_Vector),
    .InstMem_Ready(InstMem_Ready), .InstMem_Data(InstMem_Data),
    .InstMem_Read(InstMem_Read), .InstMem_Address(InstMem_Address),
    .IF_Instruction(IF_Instruction), .IF_PC(IF_PC), .IF_PCAdd4(IF_PCAdd4),
    .IF_IsBDS(IF_IsBDS), .IF_Stall(IF_Stall), .IF_Flush(IF_Flush),
    .IF_EXC_AdIF(IF_EXC_AdIF), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, bench did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b11} ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic bds, input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({bds, pc, instr});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Memory model: answers each read after wait_states idle cycles, updated 2ns after the clock edge.
  always begin
    @(posedge clock);
    #2;
    if (reset || !InstMem_Read) begin
      InstMem_Ready = 1'b0;
      InstMem_Data  = 32'hDEAD_BEEF;
      mem_cnt       = 0;
    end else if (mem_cnt == wait_states) begin
      InstMem_Ready = 1'b1;
      InstMem_Data  = data_override_en ? data_override : mem_word(InstMem_Address);
      mem_cnt       = 0;
    end else begin
      InstMem_Ready = 1'b0;
      InstMem_Data  = 32'hDEAD_BEEF;
      mem_cnt++;
    end
  end

  // Monitor: every instruction taken by IF/ID must match the head of the expected queue.
  always @(negedge clock) begin
    if (!reset && !IF_Stall && !ID_Stall) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_consume: got pc=%h instr=%h, expected no instruction", IF_PC, IF_Instruction);
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_pc", IF_PC, mon_e[63:32]);
        check("mon_instr", IF_Instruction, mon_e[31:0]);
        check("mon_pcadd4", IF_PCAdd4, mon_e[63:32] + 32'd4);
        check("mon_bds", {31'd0, IF_IsBDS}, {31'd0, mon_e[64]});
      end
    end
  end

  task automatic do_reset(input int ws);
    check("queue_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    reset = 1'b1; ID_Stall = 1'b1; ID_PCSrc = 1'b0; ID_IsBranch = 1'b0;
    ID_CancelBDS = 1'b0; Exc_Redirect = 1'b0; ID_TargetPC = 32'd0; Exc_Vector = 32'd0;
    data_override_en = 1'b0; wait_states = ws;
    step();
    step();
  endtask

  initial begin
    InstMem_Ready = 1'b0;
    InstMem_Data  = 32'hDEAD_BEEF;
    // Reset outputs, with redirect/cancel requests active to prove they are masked
    reset = 1'b1; ID_Stall = 1'b1; ID_PCSrc = 1'b0; ID_IsBranch = 1'b0;
    ID_CancelBDS = 1'b1; Exc_Redirect = 1'b1; ID_TargetPC = 32'd0; Exc_Vector = 32'h8000_0180;
    step();
    step();
    #3;
    check("rst_read", {31'd0, InstMem_Read}, 32'd0);
    check("rst_stall", {31'd0, IF_Stall}, 32'd1);
    check("rst_flush", {31'd0, IF_Flush}, 32'd0);
    check("rst_adif", {31'd0, IF_EXC_AdIF}, 32'd0);
    check("rst_instr", IF_Instruction, 32'd0);
    check("rst_pc", IF_PC, 32'hBFC0_0000);
    check("rst_pcadd4", IF_PCAdd4, 32'hBFC0_0004);

    // Sequential fetch, zero-wait memory
    do_reset(0);
    reset = 1'b0; ID_Stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 32'hBFC0_0000 + 32'(4 * i), mem_word(30'h2FF0_0000 + 30'(i)));
      #3;
      check("seq_addr", {2'b00, InstMem_Address}, 32'h2FF0_0000 + 32'(i));
      check("seq_stall", {31'd0, IF_Stall}, 32'd0);
      step();
    end
    ID_Stall = 1'b1;
    step();

    // Three wait states
    do_reset(3);
    reset = 1'b0; ID_Stall = 1'b0;
    push(1'b0, 32'hBFC0_0000, mem_word(30'h2FF0_0000));
    for (int i = 0; i < 3; i++) begin
      #3;
      check("ws_stall", {31'd0, IF_Stall}, 32'd1);
      step();
    end
    #3;
    check("ws_stall_done", {31'd0, IF_Stall}, 32'd0);
    check("ws_pc", IF_PC, 32'hBFC0_0000);
    step();
    ID_Stall = 1'b1;
    step();

    // Taken branch with its delay slot
    do_reset(0);
    reset = 1'b0; ID_Stall = 1'b0;
    push(1'b0, 32'hBFC0_0000, mem_word(30'h2FF0_0000));
    step();
    push(1'b0, 32'hBFC0_0004, mem_word(30'h2FF0_0001));
    step();
    ID_IsBranch = 1'b1; ID_PCSrc = 1'b1; ID_TargetPC = 32'h8000_0100;
    push(1'b1, 32'hBFC0_0008, mem_word(30'h2FF0_0002));
    #3;
    check("br_bds", {31'd0, IF_IsBDS}, 32'd1);
    step();
    ID_IsBranch = 1'b0; ID_PCSrc = 1'b0;
    push(1'b0, 32'h8000_0100, mem_word(30'h2000_0040));
    #3;
    check("br_target_addr", {2'b00, InstMem_Address}, 32'h2000_0040);
    step();
    ID_Stall = 1'b1;
    step();

    // Exception while a read is outstanding
    do_reset(3);
    reset = 1'b0; ID_Stall = 1'b0;
    step();
    Exc_Redirect = 1'b1; Exc_Vector = 32'h8000_0180;
    #3;
    check("exc_flush", {31'd0, IF_Flush}, 32'd1);
    check("exc_stall", {31'd0, IF_Stall}, 32'd1);
    step();
    Exc_Redirect = 1'b0;
    #3;
    check("exc_discard_state", {30'd0, dbg_state}, 32'd2);
    check("exc_discard_stall", {31'd0, IF_Stall}, 32'd1);
    step();
    #3;
    check("exc_drain_dropped", {31'd0, IF_Stall}, 32'd1);
    step();
    push(1'b0, 32'h8000_0180, mem_word(30'h2000_0060));
    #3;
    check("exc_new_read", {31'd0, InstMem_Read}, 32'd1);
    check("exc_new_addr", {2'b00, InstMem_Address}, 32'h2000_0060);
    step();
    for (int i = 0; i < 2; i++) begin
      #3;
      check("exc_wait_stall", {31'd0, IF_Stall}, 32'd1);
      step();
    end
    #3;
    check("exc_arrive", {31'd0, IF_Stall}, 32'd0);
    step();
    ID_Stall = 1'b1;
    step();

    // Stall as data arrives, with a simultaneous branch-likely cancel
    do_reset(0);
    reset = 1'b0; ID_Stall = 1'b1; ID_CancelBDS = 1'b1;
    data_override_en = 1'b1; data_override = 32'h2402_0005;
    #3;
    check("hold_stall", {31'd0, IF_Stall}, 32'd0);
    check("hold_instr_arrive", IF_Instruction, 32'h2402_0005);
    check("hold_flush", {31'd0, IF_Flush}, 32'd1);
    step();
    ID_CancelBDS = 1'b0; data_override_en = 1'b0;
    #3;
    check("hold_read", {31'd0, InstMem_Read}, 32'd0);
    check("hold_instr_kept", IF_Instruction, 32'h2402_0005);
    check("hold_pc", IF_PC, 32'hBFC0_0000);
    step();
    ID_Stall = 1'b0;
    push(1'b0, 32'hBFC0_0000, 32'h2402_0005);
    step();
    push(1'b0, 32'hBFC0_0004, mem_word(30'h2FF0_0001));
    #3;
    check("hold_next_addr", {2'b00, InstMem_Address}, 32'h2FF0_0001);
    step();
    ID_Stall = 1'b1;
    step();

    // Branch and exception together: the exception wins
    do_reset(0);
    reset = 1'b0; ID_Stall = 1'b0;
    ID_PCSrc = 1'b1; ID_TargetPC = 32'h8000_0100;
    Exc_Redirect = 1'b1; Exc_Vector = 32'h8000_0180;
    push(1'b0, 32'hBFC0_0000, mem_word(30'h2FF0_0000));
    step();
    ID_PCSrc = 1'b0; Exc_Redirect = 1'b0;
    push(1'b0, 32'h8000_0180, mem_word(30'h2000_0060));
    #3;
    check("prio_addr", {2'b00, InstMem_Address}, 32'h2000_0060);
    step();
    ID_Stall = 1'b1;
    step();

    // Misaligned redirect target
    do_reset(0);
    reset = 1'b0; ID_Stall = 1'b0;
    ID_PCSrc = 1'b1; ID_TargetPC = 32'h8000_0102;
    push(1'b0, 32'hBFC0_0000, mem_word(30'h2FF0_0000));
    step();
    ID_PCSrc = 1'b0;
`ifdef IF_ADDR_ERR_EN
    push(1'b0, 32'h8000_0102, 32'd0);
    #3;
    check("mis_adif", {31'd0, IF_EXC_AdIF}, 32'd1);
    check("mis_read", {31'd0, InstMem_Read}, 32'd0);
    check("mis_instr", IF_Instruction, 32'd0);
    step();
    ID_PCSrc = 1'b1; ID_TargetPC = 32'h8000_0100;
    push(1'b0, 32'h8000_0102, 32'd0);
    #3;
    check("mis_pc_held", IF_PC, 32'h8000_0102);
    step();
    ID_PCSrc = 1'b0;
    push(1'b0, 32'h8000_0100, mem_word(30'h2000_0040));
    #3;
    check("mis_recover_adif", {31'd0, IF_EXC_AdIF}, 32'd0);
    check("mis_recover_addr", {2'b00, InstMem_Address}, 32'h2000_0040);
    step();
`else
    push(1'b0, 32'h8000_0102, mem_word(30'h2000_0040));
    #3;
    check("mis_adif_off", {31'd0, IF_EXC_AdIF}, 32'd0);
    check("mis_read_off", {31'd0, InstMem_Read}, 32'd1);
    check("mis_addr_off", {2'b00, InstMem_Address}, 32'h2000_0040);
    step();
`endif
    ID_Stall = 1'b1;
    step();

    check("final_queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
